// File: rtl/xadc_pkg.sv
// rtl/xadc_pkg.sv - shared widths and FSM state type for the XADC millivolt/BCD converter
// Contents: ADC_BITS, BCD_DIGITS, MV_BITS, DD_ITERATIONS, derived widths, state_t.
package xadc_pkg;

   localparam int ADC_BITS      = 12;
   localparam int BCD_DIGITS    = 4;
   localparam int MV_BITS       = 14;
   localparam int DD_ITERATIONS = 14;

   localparam int BCD_BITS  = 4 * BCD_DIGITS;
   // Double-dabble register: BCD digits on top, binary millivolts below.
   localparam int DD_BITS   = BCD_BITS + MV_BITS;
   localparam int ITER_BITS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCALE = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble add-3 correction for one BCD digit
// Ports: i_digit [3:0] digit before shift, o_digit [3:0] digit + 3 when >= 5, else unchanged.
module bcd_digit_adj (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/xadc_bcd_converter.sv
// rtl/xadc_bcd_converter.sv - converts a 12-bit XADC code to millivolts and packed BCD
// Ports: clk, reset (async, active-high), code_in[15:0] / code_valid sample strobe,
//        ready (IDLE only), mv_out[13:0], bcd_out[15:0], bcd_valid pulse, overrun_cnt[7:0].
module xadc_bcd_converter
   import xadc_pkg::*;
#(
   parameter int FULL_SCALE_MV = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] code_in,
   input  logic        code_valid,
   output logic        ready,
   output logic [13:0] mv_out,
   output logic [15:0] bcd_out,
   output logic        bcd_valid,
   output logic [7:0]  overrun_cnt
);

   localparam logic [MV_BITS-1:0]   FS_MV     = MV_BITS'(FULL_SCALE_MV);
   localparam logic [ITER_BITS-1:0] LAST_ITER = ITER_BITS'(DD_ITERATIONS - 1);

   state_t                      r_state;
   state_t                      w_next_state;
   logic [ADC_BITS-1:0]         r_code;
   logic [MV_BITS-1:0]          r_mv;
   logic [DD_BITS-1:0]          r_dd;
   logic [ITER_BITS-1:0]        r_iter;
   logic                        r_ready;
   logic [MV_BITS-1:0]          r_mv_out;
   logic [BCD_BITS-1:0]         r_bcd_out;
   logic                        r_bcd_valid;
   logic [7:0]                  r_overrun;

   logic [ADC_BITS+MV_BITS-1:0] w_product;
   logic [MV_BITS-1:0]          w_mv;
   logic [DD_BITS-1:0]          w_dd_adj;
   logic [DD_BITS-1:0]          w_dd_shift;
   logic                        w_last;
   logic                        w_accept;
   logic                        w_drop;
   logic                        w_load;
   logic                        w_shift;
   logic                        w_publish;
   logic                        w_unused_bits;

   // Full 26-bit product so the >>12 truncation never loses high bits.
   assign w_product = {{MV_BITS{1'b0}}, r_code} * {{ADC_BITS{1'b0}}, FS_MV};
   assign w_mv      = w_product[ADC_BITS +: MV_BITS];
   assign w_last    = (r_iter == LAST_ITER);

   // Upper code nibble and the fractional product bits are intentionally discarded.
   assign w_unused_bits = ^{code_in[15:12], w_product[ADC_BITS-1:0]};

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
      bcd_digit_adj u_adj (
         .i_digit (r_dd[MV_BITS + 4*g +: 4]),
         .o_digit (w_dd_adj[MV_BITS + 4*g +: 4])
      );
   end
   assign w_dd_adj[MV_BITS-1:0] = r_dd[MV_BITS-1:0];
   assign w_dd_shift            = {w_dd_adj[DD_BITS-2:0], 1'b0};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:  if (code_valid) w_next_state = SCALE;
         SCALE: w_next_state = SHIFT;
         SHIFT: if (w_last) w_next_state = DONE;
         DONE:  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Output/control decode
   always_comb begin
      w_accept  = 1'b0;
      w_drop    = 1'b0;
      w_load    = 1'b0;
      w_shift   = 1'b0;
      w_publish = 1'b0;
      case (r_state)
         IDLE:  w_accept = code_valid;
         SCALE: begin
            w_load = 1'b1;
            w_drop = code_valid;
         end
         SHIFT: begin
            w_shift   = 1'b1;
            // Results are registered on the last shift so bcd_valid is high during DONE.
            w_publish = w_last;
            w_drop    = code_valid;
         end
         DONE:  w_drop = code_valid;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_code      <= '0;
         r_mv        <= '0;
         r_dd        <= '0;
         r_iter      <= '0;
         r_ready     <= 1'b1;
         r_mv_out    <= '0;
         r_bcd_out   <= '0;
         r_bcd_valid <= 1'b0;
         r_overrun   <= '0;
      end else begin
         r_ready     <= (w_next_state == IDLE);
         r_bcd_valid <= w_publish;
         if (w_accept) r_code <= code_in[ADC_BITS-1:0];
         if (w_load) begin
            r_mv   <= w_mv;
            r_dd   <= {{BCD_BITS{1'b0}}, w_mv};
            r_iter <= '0;
         end else if (w_shift) begin
            r_dd   <= w_dd_shift;
            r_iter <= r_iter + 1'b1;
         end
         if (w_publish) begin
            r_mv_out  <= r_mv;
            r_bcd_out <= w_dd_shift[DD_BITS-1 -: BCD_BITS];
         end
         if (w_drop && (r_overrun != 8'hFF)) r_overrun <= r_overrun + 8'd1;
      end
   end

   assign ready       = r_ready;
   assign mv_out      = r_mv_out;
   assign bcd_out     = r_bcd_out;
   assign bcd_valid   = r_bcd_valid;
   assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_xadc_bcd_converter.sv
// tb/tb_xadc_bcd_converter.sv - self-checking bench for xadc_bcd_converter at 1000 mV and 3300 mV full scale
module tb_xadc_bcd_converter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] code_in = 16'h0000;
   logic        code_valid = 1'b0;

   logic        rdy_a, bv_a, rdy_b, bv_b;
   logic [13:0] mv_a, mv_b;
   logic [15:0] bcd_a, bcd_b;
   logic [7:0]  ovr_a, ovr_b;

   logic        rdy [2];
   logic        bv  [2];
   logic [13:0] mv  [2];
   logic [15:0] bcd [2];
   logic [7:0]  ovr [2];
   int          fs_tab [2] = '{1000, 3300};

   int errors = 0;
   int checks = 0;
   int exp_ovr = 0;

   always #5 clk = ~clk;

   xadc_bcd_converter #(.FULL_SCALE_MV(1000)) dut_a (
      .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
      .ready(rdy_a), .mv_out(mv_a), .bcd_out(bcd_a), .bcd_valid(bv_a), .overrun_cnt(ovr_a)
   );

   xadc_bcd_converter #(.FULL_SCALE_MV(3300)) dut_b (
      .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
      .ready(rdy_b), .mv_out(mv_b), .bcd_out(bcd_b), .bcd_valid(bv_b), .overrun_cnt(ovr_b)
   );

   assign rdy[0] = rdy_a;  assign rdy[1] = rdy_b;
   assign bv[0]  = bv_a;   assign bv[1]  = bv_b;
   assign mv[0]  = mv_a;   assign mv[1]  = mv_b;
   assign bcd[0] = bcd_a;  assign bcd[1] = bcd_b;
   assign ovr[0] = ovr_a;  assign ovr[1] = ovr_b;

   function automatic int ref_mv(input logic [15:0] code, input int fs);
      return (int'(code & 16'h0FFF) * fs) / 4096;
   endfunction

   function automatic logic [15:0] ref_bcd(input int m);
      return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   // One conversion; extra strobes are injected so they are sampled at edges d1/d2 after accept.
   task automatic run_conv(input logic [15:0] code, input int d1, input int d2);
      @(negedge clk);
      code_in    = code;
      code_valid = 1'b1;
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      code_in    = 16'($urandom);
      for (int n = 1; n <= 16; n++) begin
         if (n == d1 || n == d2) code_valid = 1'b1;
         @(posedge clk);
         #1;
         code_valid = 1'b0;
         if (n == d1 || n == d2) exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (bv[d] !== (n == 15)) begin
               errors++;
               $display("FAIL bcd_valid dut%0d code=%h n=%0d got=%b exp=%b", d, code, n, bv[d], (n == 15));
            end
            checks++;
            if (rdy[d] !== (n == 16)) begin
               errors++;
               $display("FAIL ready dut%0d code=%h n=%0d got=%b exp=%b", d, code, n, rdy[d], (n == 16));
            end
            if (n == 15) begin
               checks++;
               if (mv[d] !== 14'(ref_mv(code, fs_tab[d]))) begin
                  errors++;
                  $display("FAIL mv_out dut%0d code=%h got=%0d exp=%0d", d, code, mv[d], ref_mv(code, fs_tab[d]));
               end
               checks++;
               if (bcd[d] !== ref_bcd(ref_mv(code, fs_tab[d]))) begin
                  errors++;
                  $display("FAIL bcd_out dut%0d code=%h got=%h exp=%h", d, code, bcd[d], ref_bcd(ref_mv(code, fs_tab[d])));
               end
            end
            if (n == 16) begin
               checks++;
               if (ovr[d] !== 8'(exp_ovr)) begin
                  errors++;
                  $display("FAIL overrun dut%0d got=%0d exp=%0d", d, ovr[d], exp_ovr);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({rdy[d], bv[d], mv[d], bcd[d], ovr[d]} !== {1'b1, 1'b0, 14'd0, 16'h0000, 8'd0}) begin
            errors++;
            $display("FAIL reset_state dut%0d got rdy=%b bv=%b mv=%0d bcd=%h ovr=%0d exp 1/0/0/0000/0",
                     d, rdy[d], bv[d], mv[d], bcd[d], ovr[d]);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      exp_ovr = 0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rdy[d] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset dut%0d got=%b exp=1", d, rdy[d]);
         end
      end
   endtask

   task automatic test_vectors();
      run_conv(16'h0FFF, 0, 0);
      run_conv(16'hF800, 0, 0);
      run_conv(16'h0000, 0, 0);
      run_conv(16'h0001, 0, 0);
   endtask

   task automatic test_random();
      repeat (8) begin
         run_conv(16'($urandom), 0, 0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

   task automatic test_overrun_and_hold();
      run_conv(16'h0ABC, 3, 16);
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (bv[d] !== 1'b0 || mv[d] !== 14'(ref_mv(16'h0ABC, fs_tab[d])) || ovr[d] !== 8'(exp_ovr)) begin
               errors++;
               $display("FAIL hold dut%0d n=%0d got bv=%b mv=%0d ovr=%0d exp bv=0 mv=%0d ovr=%0d",
                        d, n, bv[d], mv[d], ovr[d], ref_mv(16'h0ABC, fs_tab[d]), exp_ovr);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      run_conv(16'h0123, 0, 0);
      run_conv(16'h0FFE, 0, 0);
      run_conv(16'h0800, 5, 0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      code_in    = 16'h0FFF;
      code_valid = 1'b1;
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      #2;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({bv[d], mv[d], bcd[d], ovr[d]} !== {1'b0, 14'd0, 16'h0000, 8'd0}) begin
            errors++;
            $display("FAIL async_reset dut%0d got bv=%b mv=%0d bcd=%h ovr=%0d exp 0/0/0000/0",
                     d, bv[d], mv[d], bcd[d], ovr[d]);
         end
      end
      @(negedge clk);
      reset   = 1'b0;
      exp_ovr = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (bv[d] !== 1'b0 || rdy[d] !== 1'b1 || bcd[d] !== 16'h0000) begin
               errors++;
               $display("FAIL aborted dut%0d n=%0d got bv=%b rdy=%b bcd=%h exp 0/1/0000", d, n, bv[d], rdy[d], bcd[d]);
            end
         end
      end
      run_conv(16'h0800, 0, 0);
   endtask

   task automatic test_saturate();
      test_reset();
      // Strobe held for 100 edges: accepted at 0,17,34,51,68,85, the other 94 dropped.
      @(negedge clk);
      code_valid = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      code_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ovr[d] !== 8'd94) begin
            errors++;
            $display("FAIL overrun_count dut%0d got=%0d exp=94", d, ovr[d]);
         end
      end
      @(negedge clk);
      code_valid = 1'b1;
      repeat (340) @(posedge clk);
      #1;
      code_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ovr[d] !== 8'd255) begin
            errors++;
            $display("FAIL overrun_saturate dut%0d got=%0d exp=255", d, ovr[d]);
         end
         checks++;
         if (rdy[d] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_saturate dut%0d got=%b exp=1", d, rdy[d]);
         end
      end
      exp_ovr = 255;
      run_conv(16'h0FFF, 4, 0);
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_overrun_and_hold();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xadc_bcd_converter.md
XADC_BCD_CONVERTER -- requirements
Module: xadc_bcd_converter

Interface
REQ-001 SHALL have parameter FULL_SCALE_MV, default 1000, millivolts represented by a full-scale code (legal 1..9999).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port code_in  input  16  XADC sample; bits [11:0] used, bits [15:12] ignored.
REQ-005 SHALL have port code_valid  input  1  one-cycle strobe qualifying code_in (driven from XADC drdy).
REQ-006 SHALL have port ready  output  1  high only in IDLE; code_valid accepted only when ready=1.
REQ-007 SHALL have port mv_out  output  14  converted value in millivolts, binary.
REQ-008 SHALL have port bcd_out  output  16  four packed BCD digits of mv_out, thousands in [15:12].
REQ-009 SHALL have port bcd_valid  output  1  one-cycle pulse when mv_out/bcd_out update.
REQ-010 SHALL have port overrun_cnt  output  8  saturating count of dropped samples.

Function
REQ-011 SHALL implement an FSM with states IDLE, SCALE, SHIFT, DONE.
REQ-012 IDLE: on code_valid=1, SHALL latch code_in[11:0] and go to SCALE; otherwise stay in IDLE.
REQ-013 SCALE (1 cycle): SHALL compute mv = (code*FULL_SCALE_MV)>>12 (truncate, >=26-bit product), load mv into double-dabble register, clear iteration counter, go to SHIFT.
REQ-014 SHIFT: SHALL run exactly 14 iterations, one per cycle; each iteration adds 3 to every BCD digit >=5, then shifts left 1; after the 14th go to DONE.
REQ-015 DONE (1 cycle): SHALL register mv_out and bcd_out, drive bcd_valid=1 that cycle, then return to IDLE.
REQ-016 Latency SHALL be fixed: bcd_valid high in the 16th cycle after the accepting edge; accepted samples have a throughput of one per 17 cycles.
REQ-017 mv_out and bcd_out SHALL hold their values between bcd_valid pulses.
REQ-018 code_valid while ready=0 (SCALE, SHIFT, DONE) SHALL be dropped, overrun_cnt SHALL increment, and the in-flight conversion SHALL be unaffected.
REQ-019 overrun_cnt SHALL saturate at 255 and not wrap.
REQ-020 For every legal FULL_SCALE_MV, mv SHALL be <=9998, so bcd_out never exceeds 0x9999.
REQ-021 code_valid in the same cycle DONE returns to IDLE SHALL count as dropped (ready=0 in DONE).

Reset
REQ-022 Reset SHALL asynchronously force state=IDLE, mv_out=0, bcd_out=0x0000, bcd_valid=0, overrun_cnt=0, counter and shift register=0; ready SHALL be 1 after release.
REQ-023 Reset asserted mid-conversion SHALL abort it with no bcd_valid pulse; the first accepted sample after release SHALL convert normally.

Structure
REQ-024 Shared package xadc_pkg SHALL hold ADC_BITS=12, BCD_DIGITS=4, MV_BITS=14, DD_ITERATIONS=14 and the FSM state enum.
REQ-025 The add-3 digit correction SHALL be sub-module bcd_digit_adj (4-bit in, 4-bit out, combinational), instantiated once per digit.
REQ-026 All outputs SHALL be registered.

Verification
REQ-027 FULL_SCALE_MV=1000: code_in=0x0FFF pulse -> 16 cycles later bcd_valid=1, mv_out=999, bcd_out=0x0999.
REQ-028 FULL_SCALE_MV=1000: code_in=0xF800 -> mv_out=500, bcd_out=0x0500 (upper nibble ignored); code_in=0x0000 -> 0x0000.
REQ-029 FULL_SCALE_MV=3300: code_in=0x0FFF -> mv_out=3299, bcd_out=0x3299.
REQ-030 code_valid 3 cycles after an accept, and again in the DONE cycle -> overrun_cnt=2, first result correct, one bcd_valid only.
REQ-031 300 strobes while busy -> overrun_cnt=255.
REQ-032 Reset during SHIFT -> no bcd_valid, outputs 0; next sample 0x0800 -> bcd_out=0x0500 at normal latency.
